// File: rtl/wrr_arbiter_if.sv
// Request/grant bundle between requesters and the weighted round-robin arbiter.
// The master drives requests, beat acknowledges and weights; the slave returns the registered grant.
interface wrr_arbiter_if #(
    parameter int PORTS        = 4,
    parameter int WEIGHT_WIDTH = 4
);
    localparam int IDX_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0]              request;
    logic [PORTS-1:0]              acknowledge;
    logic [PORTS*WEIGHT_WIDTH-1:0] weight;
    logic [PORTS-1:0]              grant;
    logic                          grant_valid;
    logic [IDX_WIDTH-1:0]          grant_encoded;
    logic [WEIGHT_WIDTH-1:0]       grant_credit;

    modport master (
        output request, acknowledge, weight,
        input  grant, grant_valid, grant_encoded, grant_credit
    );

    modport slave (
        input  request, acknowledge, weight,
        output grant, grant_valid, grant_encoded, grant_credit
    );
endinterface

// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a port keeps the grant for up to its weight in beats, then ownership rotates.
// Grant appears one cycle after request; on release it hands straight to the next requester with no idle bubble.
module wrr_arbiter #(
    parameter int PORTS        = 4,
    parameter int WEIGHT_WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    wrr_arbiter_if.slave  bus
);
    localparam int IDX_WIDTH = (PORTS > 1) ? $clog2(PORTS) : 1;

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                  state_q, state_d;
    logic [PORTS-1:0]        grant_q, grant_d;
    logic [IDX_WIDTH-1:0]    idx_q, idx_d;
    logic [IDX_WIDTH-1:0]    last_q, last_d;
    logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

    logic                    found;
    logic [IDX_WIDTH-1:0]    winner;
    logic [WEIGHT_WIDTH-1:0] win_weight;
    logic [WEIGHT_WIDTH-1:0] win_credit;
    logic                    beat;
    logic                    release_grant;

    // base + off with base < PORTS and 1 <= off <= PORTS, so one subtraction wraps it.
    function automatic logic [IDX_WIDTH-1:0] wrap_add(input logic [IDX_WIDTH-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= PORTS) s = s - PORTS;
        return IDX_WIDTH'(s);
    endfunction

    // Search starts just after the last owner, so it has lowest priority yet can win when alone.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 1; i <= PORTS; i++) begin
            if (!found && bus.request[wrap_add(last_q, i)]) begin
                found  = 1'b1;
                winner = wrap_add(last_q, i);
            end
        end
    end

    always_comb begin
        win_weight = bus.weight[int'(winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
        win_credit = (win_weight == '0) ? WEIGHT_WIDTH'(1) : win_weight;
    end

    assign beat          = bus.acknowledge[idx_q];
    assign release_grant = (beat && (credit_q == WEIGHT_WIDTH'(1))) || !bus.request[idx_q];

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        last_d   = last_q;
        credit_d = credit_q;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d  = GRANT;
                    grant_d  = PORTS'(1) << winner;
                    idx_d    = winner;
                    last_d   = winner;
                    credit_d = win_credit;
                end
            end
            GRANT: begin
                if (release_grant) begin
                    if (found) begin
                        grant_d  = PORTS'(1) << winner;
                        idx_d    = winner;
                        last_d   = winner;
                        credit_d = win_credit;
                    end else begin
                        // Index and last owner are kept so rotation resumes after the idle gap.
                        state_d  = IDLE;
                        grant_d  = '0;
                        credit_d = '0;
                    end
                end else if (beat) begin
                    credit_d = credit_q - WEIGHT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            idx_q    <= '0;
            last_q   <= IDX_WIDTH'(PORTS - 1);
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            credit_q <= credit_d;
        end
    end

    assign bus.grant         = grant_q;
    assign bus.grant_valid   = (state_q == GRANT);
    assign bus.grant_encoded = idx_q;
    assign bus.grant_credit  = credit_q;
endmodule

// File: tb/tb_wrr_arbiter.sv
// Bench for wrr_arbiter: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a quota/beats-used model of the arbitration rules.
module tb_wrr_arbiter;
    localparam int P  = 4;
    localparam int WW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    wrr_arbiter_if #(.PORTS(P), .WEIGHT_WIDTH(WW)) bus ();

    wrr_arbiter #(.PORTS(P), .WEIGHT_WIDTH(WW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    // Model: owner, quota granted, beats consumed; credit is quota minus beats used.
    bit m_valid = 1'b0;
    int m_owner = 0;
    int m_quota = 0;
    int m_used  = 0;
    int m_last  = P - 1;

    function automatic int pick(input logic [P-1:0] req, input int last);
        for (int i = 1; i <= P; i++) begin
            if (req[(last + i) % P]) return (last + i) % P;
        end
        return -1;
    endfunction

    function automatic int quota_of(input logic [P*WW-1:0] w, input int p);
        int q;
        q = int'(w[p*WW +: WW]);
        return (q == 0) ? 1 : q;
    endfunction

    always @(posedge clk or posedge rst) begin
        int nxt;
        bit done;
        if (rst) begin
            m_valid = 1'b0;
            m_owner = 0;
            m_quota = 0;
            m_used  = 0;
            m_last  = P - 1;
        end else begin
            done = 1'b1;
            if (m_valid) begin
                if (bus.acknowledge[m_owner]) m_used++;
                done = !bus.request[m_owner] || (m_used == m_quota);
            end
            if (done) begin
                nxt = pick(bus.request, m_last);
                if (nxt >= 0) begin
                    m_valid = 1'b1;
                    m_owner = nxt;
                    m_last  = nxt;
                    m_quota = quota_of(bus.weight, nxt);
                    m_used  = 0;
                end else begin
                    m_valid = 1'b0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [P-1:0] eg;
        int ecr;
        if (chk_en) begin
            eg  = m_valid ? (P'(1) << m_owner) : '0;
            ecr = m_valid ? (m_quota - m_used) : 0;
            checks++;
            if (bus.grant === eg && bus.grant_valid === m_valid &&
                int'(bus.grant_encoded) == m_owner && int'(bus.grant_credit) == ecr)
                passes++;
            else
                $display("FAIL cycle_cmp t=%0t actual grant=%b valid=%b enc=%0d credit=%0d required grant=%b valid=%b enc=%0d credit=%0d",
                         $time, bus.grant, bus.grant_valid, bus.grant_encoded, bus.grant_credit,
                         eg, m_valid, m_owner, ecr);
        end
    end

    task automatic lit(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    int exp_enc2 [8] = '{0, 0, 0, 1, 1, 0, 0, 0};
    int exp_cr2  [8] = '{3, 2, 1, 2, 1, 3, 2, 1};

    initial begin
        bus.request     = '0;
        bus.acknowledge = '0;
        bus.weight      = 16'h1111;
        #1 rst = 1'b1;
        chk_en = 1'b1;
        tick();
        tick();
        lit("reset_grant", int'(bus.grant), 0);
        lit("reset_valid", int'(bus.grant_valid), 0);
        lit("reset_enc", int'(bus.grant_encoded), 0);
        lit("reset_credit", int'(bus.grant_credit), 0);
        rst = 1'b0;

        // Equal weights, all requesting, ack follows grant.
        bus.request = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            tick();
            lit("t1_enc", int'(bus.grant_encoded), k % 4);
            lit("t1_valid", int'(bus.grant_valid), 1);
            bus.acknowledge = bus.grant;
        end

        bus.request     = '0;
        bus.acknowledge = '0;
        tick();
        bus.weight  = 16'h1123;
        bus.request = 4'b0011;
        for (int k = 0; k < 8; k++) begin
            tick();
            lit("t2_enc", int'(bus.grant_encoded), exp_enc2[k]);
            lit("t2_credit", int'(bus.grant_credit), exp_cr2[k]);
            bus.acknowledge = bus.grant;
        end

        // Zero weight behaves as one; sole requester is re-granted back-to-back.
        bus.request     = '0;
        bus.acknowledge = '0;
        tick();
        bus.weight      = 16'h1023;
        bus.request     = 4'b0100;
        bus.acknowledge = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            lit("t3_enc", int'(bus.grant_encoded), 2);
            lit("t3_credit", int'(bus.grant_credit), 1);
            lit("t3_valid", int'(bus.grant_valid), 1);
        end

        bus.request     = '0;
        bus.acknowledge = '0;
        tick();
        bus.weight  = 16'h4523;
        bus.request = 4'b0100;
        tick();
        lit("t4_first_credit", int'(bus.grant_credit), 5);
        bus.acknowledge = 4'b0100;
        tick();
        tick();
        lit("t4_credit_after2", int'(bus.grant_credit), 3);
        bus.request     = 4'b1001;
        bus.acknowledge = '0;
        tick();
        lit("t4_switch_enc", int'(bus.grant_encoded), 3);
        lit("t4_switch_credit", int'(bus.grant_credit), 4);
        bus.request = '0;
        tick();
        bus.request = 4'b0100;
        tick();
        lit("t4b_enc", int'(bus.grant_encoded), 2);
        bus.acknowledge = 4'b0100;
        tick();
        tick();
        bus.request     = '0;
        bus.acknowledge = '0;
        tick();
        lit("t4b_valid", int'(bus.grant_valid), 0);
        lit("t4b_grant", int'(bus.grant), 0);
        lit("t4b_credit", int'(bus.grant_credit), 0);
        lit("t4b_enc_kept", int'(bus.grant_encoded), 2);

        // Foreign acks and mid-grant weight changes leave the credit alone.
        bus.weight  = 16'h4543;
        bus.request = 4'b0010;
        tick();
        lit("t5_enc", int'(bus.grant_encoded), 1);
        lit("t5_credit", int'(bus.grant_credit), 4);
        bus.acknowledge = 4'b1101;
        bus.weight      = 16'h4573;
        for (int k = 0; k < 3; k++) begin
            tick();
            lit("t5_hold_credit", int'(bus.grant_credit), 4);
            lit("t5_hold_grant", int'(bus.grant), 2);
        end
        bus.acknowledge = 4'b0010;
        tick();
        lit("t5_beat_credit", int'(bus.grant_credit), 3);

        // Asynchronous reset mid-grant.
        bus.request     = 4'b1000;
        bus.acknowledge = '0;
        tick();
        lit("t6_enc", int'(bus.grant_encoded), 3);
        #2 rst = 1'b1;
        #1;
        lit("t6_async_grant", int'(bus.grant), 0);
        lit("t6_async_valid", int'(bus.grant_valid), 0);
        lit("t6_async_credit", int'(bus.grant_credit), 0);
        lit("t6_async_enc", int'(bus.grant_encoded), 0);
        tick();
        bus.request = 4'b1010;
        tick();
        rst = 1'b0;
        tick();
        lit("t6_post_enc", int'(bus.grant_encoded), 1);
        lit("t6_post_grant", int'(bus.grant), 2);

        // Randomized traffic; the per-cycle comparison does the checking.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 15) == 0) bus.weight = 16'($urandom);
            bus.request = bus.request ^ (4'($urandom) & 4'($urandom));
            if ($urandom_range(0, 1) == 1)
                bus.acknowledge = bus.grant | 4'($urandom);
            else
                bus.acknowledge = 4'($urandom) & 4'($urandom);
            rst = (n % 700 == 350);
            tick();
        end
        rst = 1'b0;
        tick();
        chk_en = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
